// File: rtl/shift_deserializer.sv
// Serial-to-parallel word assembler: collects WIDTH qualified bits framed by start,
// presents each completed word through a valid/ready output register with sticky overflow.
module shift_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_in,
    input  logic             start,
    input  logic             data_ready,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid;
    logic             r_overflow;

    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_shifted;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;

    // Next-word candidates and completion/handshake decode
    always_comb begin
        w_first    = {WIDTH{1'b0}};
        w_shifted  = r_shift;
        w_complete = 1'b0;
        w_load     = 1'b0;
        w_drop     = 1'b0;
        if (MSB_FIRST) begin
            w_first   = {{(WIDTH-1){1'b0}}, data_in};
            w_shifted = {r_shift[WIDTH-2:0], data_in};
        end else begin
            w_first   = {data_in, {(WIDTH-1){1'b0}}};
            w_shifted = {data_in, r_shift[WIDTH-1:1]};
        end
        if ((r_state == S_SHIFT) && enable && !start && (r_count == CW'(WIDTH - 1))) begin
            w_complete = 1'b1;
        end else begin
            w_complete = 1'b0;
        end
        // A full output register only accepts a new word if it is being consumed on this edge.
        if (w_complete && (!r_valid || data_ready)) begin
            w_load = 1'b1;
        end else begin
            w_load = 1'b0;
        end
        if (w_complete && r_valid && !data_ready) begin
            w_drop = 1'b1;
        end else begin
            w_drop = 1'b0;
        end
    end

    // Frame FSM, bit counter and partial-word shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= {CW{1'b0}};
            r_shift <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable && start) begin
                        r_shift <= w_first;
                        r_count <= CW'(1);
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (!enable) begin
                        r_state <= S_SHIFT;
                    end else if (start) begin
                        r_shift <= w_first;
                        r_count <= CW'(1);
                        r_state <= S_SHIFT;
                    end else if (w_complete) begin
                        r_shift <= w_shifted;
                        r_count <= {CW{1'b0}};
                        r_state <= S_IDLE;
                    end else begin
                        r_shift <= w_shifted;
                        r_count <= r_count + CW'(1);
                        r_state <= S_SHIFT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_count <= {CW{1'b0}};
                    r_shift <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Output word register, valid handshake and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out <= {WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out <= w_shifted;
                r_valid    <= 1'b1;
            end else if (r_valid && data_ready) begin
                r_valid    <= 1'b0;
            end else begin
                r_valid    <= r_valid;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign busy       = (r_state == S_SHIFT);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer: MSB-first instance with full handshake,
// plus an LSB-first instance (always ready) for bit-order checking.
module tb_shift_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       data_in = 1'b0;
    logic       start = 1'b0;
    logic       data_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       overflow;
    logic [7:0] l_data_out;
    logic       l_data_valid;
    logic       l_busy;
    logic       l_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .start(start),
        .data_ready(data_ready), .clr_ovf(clr_ovf), .data_out(data_out),
        .data_valid(data_valid), .busy(busy), .overflow(overflow)
    );

    shift_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .start(start),
        .data_ready(1'b1), .clr_ovf(clr_ovf), .data_out(l_data_out),
        .data_valid(l_data_valid), .busy(l_busy), .overflow(l_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        enable  = 1'b1;
        start   = st;
        data_in = b;
        tick();
        enable  = 1'b0;
        start   = 1'b0;
        data_in = 1'b0;
    endtask

    // Sends bits first..last of w; bit 0 of the stream carries start
    task automatic send_word(input logic [7:0] w, input int first, input int last, input logic msb);
        for (int i = first; i <= last; i++) begin
            send_bit(msb ? w[7-i] : w[i], (i == 0));
        end
    endtask

    initial begin
        #2;
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid", data_valid, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_overflow", overflow, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // Basic word 0x2A with latency check
        send_word(8'h2A, 0, 0, 1'b1);
        chk("busy_after_first", busy, 32'h1);
        send_word(8'h2A, 1, 6, 1'b1);
        chk("valid_before_last", data_valid, 32'h0);
        send_word(8'h2A, 7, 7, 1'b1);
        chk("w2a_data", data_out, 32'h2A);
        chk("w2a_valid", data_valid, 32'h1);
        chk("w2a_busy", busy, 32'h0);
        data_ready = 1'b1;
        tick();
        chk("consume_valid", data_valid, 32'h0);
        data_ready = 1'b0;

        // Enable gap of 3 cycles after bit 4
        send_word(8'h2A, 0, 3, 1'b1);
        tick(); tick(); tick();
        chk("gap_busy", busy, 32'h1);
        chk("gap_valid", data_valid, 32'h0);
        send_word(8'h2A, 4, 7, 1'b1);
        chk("gap_data", data_out, 32'h2A);
        chk("gap_valid_after", data_valid, 32'h1);

        // Unread 0x2A then 0xFF -> drop and overflow
        send_word(8'hFF, 0, 7, 1'b1);
        chk("ovf_data_kept", data_out, 32'h2A);
        chk("ovf_valid", data_valid, 32'h1);
        chk("ovf_set", overflow, 32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 32'h0);

        // Ready on the completion edge -> replace, valid stays high
        send_word(8'hFF, 0, 6, 1'b1);
        data_ready = 1'b1;
        send_word(8'hFF, 7, 7, 1'b1);
        chk("replace_data", data_out, 32'hFF);
        chk("replace_valid", data_valid, 32'h1);
        chk("replace_ovf", overflow, 32'h0);
        tick();
        chk("replace_consumed", data_valid, 32'h0);
        data_ready = 1'b0;

        // Partial word aborted by a fresh start
        send_word(8'hF0, 0, 4, 1'b1);
        chk("partial_no_valid", data_valid, 32'h0);
        send_word(8'h55, 0, 7, 1'b1);
        chk("restart_data", data_out, 32'h55);
        chk("restart_valid", data_valid, 32'h1);
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;

        // Reset mid-word takes effect immediately
        send_word(8'hFF, 0, 2, 1'b1);
        chk("pre_rst_busy", busy, 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 32'h0);
        chk("mid_rst_valid", data_valid, 32'h0);
        chk("mid_rst_busy", busy, 32'h0);
        chk("mid_rst_ovf", overflow, 32'h0);
        tick();
        reset = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("nostart_busy", busy, 32'h0);
        chk("nostart_valid", data_valid, 32'h0);
        send_word(8'h81, 0, 7, 1'b1);
        chk("post_rst_data", data_out, 32'h81);
        chk("post_rst_valid", data_valid, 32'h1);

        // Back-to-back words, no dead cycle
        data_ready = 1'b1;
        send_word(8'h3C, 0, 0, 1'b1);
        chk("b2b_consumed", data_valid, 32'h0);
        data_ready = 1'b0;
        send_word(8'h3C, 1, 7, 1'b1);
        chk("b2b_data", data_out, 32'h3C);
        chk("b2b_valid", data_valid, 32'h1);

        // Drop and clear on the same edge: set wins
        send_word(8'hFF, 0, 6, 1'b1);
        clr_ovf = 1'b1;
        send_word(8'hFF, 7, 7, 1'b1);
        clr_ovf = 1'b0;
        chk("setwins_ovf", overflow, 32'h1);
        chk("setwins_data", data_out, 32'h3C);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("setwins_cleared", overflow, 32'h0);

        // LSB-first instance: stream 0,1,0,1,0,1,0,0
        send_word(8'h2A, 0, 7, 1'b0);
        chk("lsb_data", l_data_out, 32'h2A);
        chk("lsb_valid", l_data_valid, 32'h1);
        chk("lsb_busy", l_busy, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
